// File: rtl/a2d_scan_ctrl.sv
// a2d_scan_ctrl: round-robin multi-channel A2D scanner with a per-channel result file.
// Define A2D_AVG_EN to average 4 back-to-back samples per channel before storing.
module a2d_scan_ctrl #(
    parameter int unsigned NUM_CHNNL = 8,
    parameter int unsigned RES_W     = 12,
    parameter int unsigned LED_W     = 8,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned TMO_CYC   = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       led_sel,
    input  logic [2:0]       rd_chnnl,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    output logic             strt_cnv,
    output logic [2:0]       chnnl,
    output logic [RES_W-1:0] rd_res,
    output logic [LED_W-1:0] LED,
    output logic             scan_done,
    output logic             tmo_err
);
    localparam logic [3:0]  NUM_L    = 4'(NUM_CHNNL);
    localparam logic [2:0]  LAST_CH  = 3'(NUM_CHNNL - 1);
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [2:0]       gap_ptr;
    logic [15:0]      cnt;
    logic             tmo_hit;
    logic [RES_W-1:0] slot [8];

    assign ptr_nxt = (ptr == LAST_CH) ? 3'd0 : ptr + 3'd1;
    assign tmo_hit = (cnt == TMO_LAST);

`ifdef A2D_AVG_EN
    localparam int unsigned ACC_W = RES_W + 2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [1:0]       smp;
    logic             adv;

    assign acc_sum = acc + ACC_W'(res);
    // Stay on the same channel until its 4th sample lands or a sample times out.
    assign gap_ptr = adv ? ptr_nxt : ptr;
`else
    assign gap_ptr = ptr_nxt;
`endif

    // Unused slots above NUM_CHNNL never get written; out-of-range selects read 0.
    assign rd_res = ({1'b0, rd_chnnl} < NUM_L) ? slot[rd_chnnl] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            strt_cnv  <= 1'b0;
            chnnl     <= '0;
            scan_done <= 1'b0;
            tmo_err   <= 1'b0;
            LED       <= '0;
            for (int i = 0; i < 8; i++) slot[i] <= '0;
`ifdef A2D_AVG_EN
            acc <= '0;
            smp <= '0;
            adv <= 1'b0;
`endif
        end else begin
            strt_cnv  <= 1'b0;
            scan_done <= 1'b0;
            LED       <= ({1'b0, led_sel} < NUM_L) ? slot[led_sel][RES_W-1 -: LED_W] : '0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= START;
                        strt_cnv <= 1'b1;
                        chnnl    <= ptr;
                    end
                end
                START: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    // A completion on the final timeout cycle still counts as success.
                    if (cnv_cmplt) begin
`ifdef A2D_AVG_EN
                        if (smp == 2'd3) begin
                            slot[ptr] <= acc_sum[ACC_W-1:2];
                            scan_done <= (ptr == LAST_CH);
                            acc       <= '0;
                            smp       <= '0;
                            adv       <= 1'b1;
                        end else begin
                            acc <= acc_sum;
                            smp <= smp + 2'd1;
                            adv <= 1'b0;
                        end
`else
                        slot[ptr] <= res;
                        scan_done <= (ptr == LAST_CH);
`endif
                        state <= GAP;
                        cnt   <= '0;
                    end else if (tmo_hit) begin
                        tmo_err <= 1'b1;
                        state   <= GAP;
                        cnt     <= '0;
`ifdef A2D_AVG_EN
                        acc <= '0;
                        smp <= '0;
                        adv <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        ptr <= gap_ptr;
                        if (en) begin
                            state    <= START;
                            strt_cnv <= 1'b1;
                            chnnl    <= gap_ptr;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_a2d_scan_ctrl.sv
// tb_a2d_scan_ctrl: directed scenarios for a2d_scan_ctrl (4 channels, GAP_CYC=2, TMO_CYC=16).
// Define A2D_AVG_EN for both files to also exercise the averaging build.
module tb_a2d_scan_ctrl;
    localparam int unsigned NUM_CHNNL = 4;
    localparam int unsigned RES_W     = 12;
    localparam int unsigned LED_W     = 8;
    localparam int unsigned GAP_CYC   = 2;
    localparam int unsigned TMO_CYC   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [2:0]       led_sel;
    logic [2:0]       rd_chnnl;
    logic             cnv_cmplt;
    logic [RES_W-1:0] res;
    logic             strt_cnv;
    logic [2:0]       chnnl;
    logic [RES_W-1:0] rd_res;
    logic [LED_W-1:0] LED;
    logic             scan_done;
    logic             tmo_err;

    // A2D model controls
    logic             rsp_on;
    int               rsp_dly;
    logic [RES_W-1:0] rsp_add;
    logic [7:0]       rsp_mute;
    logic             rsp_ramp;
    logic             rsp_cmplt;
    logic [RES_W-1:0] rsp_res;
    logic             man_cmplt;
    logic [RES_W-1:0] man_res;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int q_ch[$];
    int q_cyc[$];
    int done_cnt;
    int tmo_cyc;
    bit tmo_seen;

    assign cnv_cmplt = rsp_cmplt | man_cmplt;
    assign res       = man_cmplt ? man_res : rsp_res;

    a2d_scan_ctrl #(
        .NUM_CHNNL(NUM_CHNNL), .RES_W(RES_W), .LED_W(LED_W),
        .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .led_sel(led_sel), .rd_chnnl(rd_chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .rd_res(rd_res), .LED(LED), .scan_done(scan_done), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge
    initial begin : monitor
        done_cnt = 0;
        tmo_seen = 1'b0;
        tmo_cyc  = 0;
        forever begin
            @(negedge clk);
            if (strt_cnv === 1'b1) begin
                q_ch.push_back(int'(chnnl));
                q_cyc.push_back(cyc);
            end
            if (scan_done === 1'b1) done_cnt++;
            if (tmo_err === 1'b1 && !tmo_seen) begin
                tmo_seen = 1'b1;
                tmo_cyc  = cyc;
            end
        end
    end

    // A2D_intf model: answers rsp_dly cycles after strt_cnv unless the channel is muted
    initial begin : responder
        int ch;
        int ramp_n;
        ramp_n    = 0;
        rsp_cmplt = 1'b0;
        rsp_res   = '0;
        forever begin
            @(posedge clk); #1;
            if (strt_cnv === 1'b1 && rsp_on && !rsp_mute[chnnl]) begin
                ch = int'(chnnl);
                repeat (rsp_dly) @(posedge clk);
                #1;
                if (rsp_ramp) begin
                    ramp_n++;
                    rsp_res = 12'(ramp_n);
                end else begin
                    rsp_res = 12'(256 * (ch + 1)) + rsp_add;
                end
                rsp_cmplt = 1'b1;
                @(posedge clk); #1;
                rsp_cmplt = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, errors so far=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_starts(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (q_ch.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        ok = (q_ch.size() >= n);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n0;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (strt_cnv !== 1'b0) begin errors++; $display("FAIL reset_strt_cnv: got %0b want 0", strt_cnv); end
        checks++; if (chnnl !== 3'd0) begin errors++; $display("FAIL reset_chnnl: got %0d want 0", chnnl); end
        checks++; if (rd_res !== 12'h000) begin errors++; $display("FAIL reset_rd_res: got %0h want 0", rd_res); end
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL reset_led: got %0h want 0", LED); end
        checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done: got %0b want 0", scan_done); end
        checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL reset_tmo_err: got %0b want 0", tmo_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b0;
        n0    = q_ch.size();
        repeat (100) @(posedge clk);
        #1;
        checks++; if (q_ch.size() != n0) begin errors++; $display("FAIL idle_no_start: got %0d starts want 0", q_ch.size() - n0); end
    endtask

    task automatic test_scan_wrap();
        int n0, d0;
        bit ok;
        n0 = q_ch.size();
        d0 = done_cnt;
        rsp_on = 1'b1; rsp_dly = 5; rsp_add = '0; rsp_mute = '0; rsp_ramp = 1'b0;
        en = 1'b1;
        wait_starts(n0 + 5, 200, ok);
        en = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL scan_starts: got %0d starts want 5 within budget", q_ch.size() - n0); end
        for (int i = 0; i < 5 && ok; i++) begin
            checks++;
            if (q_ch[n0+i] != i % 4) begin errors++; $display("FAIL scan_seq[%0d]: got ch %0d want %0d", i, q_ch[n0+i], i % 4); end
        end
        checks++; if (q_ch.size() != n0 + 5) begin errors++; $display("FAIL scan_stop: got %0d starts want 5", q_ch.size() - n0); end
        checks++; if (ok && q_cyc[n0+1] - q_cyc[n0] != 9) begin errors++; $display("FAIL scan_spacing: got %0d cycles want 9", q_cyc[n0+1] - q_cyc[n0]); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL scan_done_count: got %0d want 1", done_cnt - d0); end
        rd_chnnl = 3'd2; #1;
        checks++; if (rd_res !== 12'h300) begin errors++; $display("FAIL scan_rd_ch2: got %0h want 300", rd_res); end
        rd_chnnl = 3'd5; #1;
        checks++; if (rd_res !== 12'h000) begin errors++; $display("FAIL scan_rd_oob: got %0h want 0", rd_res); end
        led_sel = 3'd3;
        @(posedge clk); #1;
        checks++; if (LED !== 8'h40) begin errors++; $display("FAIL scan_led_ch3: got %0h want 40", LED); end
        led_sel = 3'd6;
        @(posedge clk); #1;
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL scan_led_oob: got %0h want 0", LED); end
    endtask

    task automatic test_timeout();
        int n0, d0;
        bit ok;
        n0 = q_ch.size();
        d0 = done_cnt;
        rsp_add  = 12'h00A;
        rsp_mute = 8'b0000_1010;
        en = 1'b1;
        wait_starts(n0 + 4, 300, ok);
        en = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checks++; if (!ok) begin errors++; $display("FAIL tmo_starts: got %0d starts want 4 within budget", q_ch.size() - n0); end
        for (int i = 0; i < 4 && ok; i++) begin
            checks++;
            if (q_ch[n0+i] != (i + 1) % 4) begin errors++; $display("FAIL tmo_seq[%0d]: got ch %0d want %0d", i, q_ch[n0+i], (i + 1) % 4); end
        end
        checks++; if (ok && q_cyc[n0+1] - q_cyc[n0] != 20) begin errors++; $display("FAIL tmo_spacing: got %0d cycles want 20", q_cyc[n0+1] - q_cyc[n0]); end
        checks++; if (!tmo_seen || (ok && tmo_cyc - q_cyc[n0] != 17)) begin errors++; $display("FAIL tmo_rise: seen %0b after %0d cycles want 17", tmo_seen, tmo_cyc - q_cyc[n0]); end
        checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %0b want 1", tmo_err); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL tmo_no_scan_done: got %0d pulses want 0", done_cnt - d0); end
        rd_chnnl = 3'd0; #1;
        checks++; if (rd_res !== 12'h10A) begin errors++; $display("FAIL tmo_slot0: got %0h want 10a", rd_res); end
        rd_chnnl = 3'd1; #1;
        checks++; if (rd_res !== 12'h200) begin errors++; $display("FAIL tmo_slot1_kept: got %0h want 200", rd_res); end
        rd_chnnl = 3'd2; #1;
        checks++; if (rd_res !== 12'h30A) begin errors++; $display("FAIL tmo_slot2: got %0h want 30a", rd_res); end
        rd_chnnl = 3'd3; #1;
        checks++; if (rd_res !== 12'h400) begin errors++; $display("FAIL tmo_slot3_kept: got %0h want 400", rd_res); end
    endtask

    task automatic test_cmplt_on_timeout();
        int n0;
        bit ok;
        pulse_reset();
        n0 = q_ch.size();
        rsp_mute = '0;
        rsp_dly  = 16;
        rsp_add  = 12'h0B0;
        en = 1'b1;
        wait_starts(n0 + 1, 20, ok);
        en = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rd_chnnl = 3'd0; #1;
        checks++; if (!ok) begin errors++; $display("FAIL simul_start: got %0d starts want 1", q_ch.size() - n0); end
        checks++; if (rd_res !== 12'h1B0) begin errors++; $display("FAIL simul_stored: got %0h want 1b0", rd_res); end
        checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL simul_no_tmo: got %0b want 0", tmo_err); end
        checks++; if (q_ch.size() != n0 + 1) begin errors++; $display("FAIL simul_idle: got %0d starts want 1", q_ch.size() - n0); end
    endtask

    task automatic test_stray_and_latency();
        int n0;
        bit ok;
        rsp_on   = 1'b0;
        rsp_dly  = 5;
        led_sel  = 3'd1;
        rd_chnnl = 3'd1;
        @(posedge clk); #1;
        n0 = q_ch.size();
        en = 1'b1;
        wait_starts(n0 + 1, 20, ok);
        en = 1'b0;
        checks++; if (!ok || chnnl !== 3'd1) begin errors++; $display("FAIL stray_start_ch: got %0d want 1", chnnl); end
        repeat (2) @(posedge clk);
        #1;
        man_res   = 12'h5A5;
        man_cmplt = 1'b1;
        @(posedge clk); #1;
        man_cmplt = 1'b0;
        checks++; if (rd_res !== 12'h5A5) begin errors++; $display("FAIL lat_rd_res: got %0h want 5a5", rd_res); end
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL lat_led_early: got %0h want 0", LED); end
        man_res   = 12'hFFF;
        man_cmplt = 1'b1;
        @(posedge clk); #1;
        man_cmplt = 1'b0;
        checks++; if (LED !== 8'h5A) begin errors++; $display("FAIL lat_led: got %0h want 5a", LED); end
        repeat (20) @(posedge clk);
        #1;
        checks++; if (rd_res !== 12'h5A5) begin errors++; $display("FAIL stray_ignored: got %0h want 5a5", rd_res); end
        checks++; if (q_ch.size() != n0 + 1) begin errors++; $display("FAIL stray_idle: got %0d starts want 1", q_ch.size() - n0); end
    endtask

    task automatic test_en_drop();
        int n0;
        bit ok;
        rsp_on  = 1'b1;
        rsp_add = '0;
        n0 = q_ch.size();
        en = 1'b1;
        wait_starts(n0 + 1, 20, ok);
        en = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        rd_chnnl = 3'd2; #1;
        checks++; if (!ok || q_ch.size() != n0 + 1) begin errors++; $display("FAIL endrop_starts: got %0d want 1", q_ch.size() - n0); end
        checks++; if (rd_res !== 12'h300) begin errors++; $display("FAIL endrop_stored: got %0h want 300", rd_res); end
    endtask

    task automatic test_reset_mid_wait();
        int n1;
        bit ok;
        en = 1'b1;
        wait_starts(q_ch.size() + 1, 20, ok);
        en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n1 = q_ch.size();
        repeat (30) @(posedge clk);
        #1;
        checks++; if (!ok || q_ch.size() != n1) begin errors++; $display("FAIL rstmid_idle: start seen %0b, later starts %0d want 0", ok, q_ch.size() - n1); end
        checks++; if (chnnl !== 3'd0) begin errors++; $display("FAIL rstmid_chnnl: got %0d want 0", chnnl); end
        checks++; if (LED !== 8'h00) begin errors++; $display("FAIL rstmid_led: got %0h want 0", LED); end
        for (int i = 0; i < 4; i++) begin
            rd_chnnl = 3'(i); #1;
            checks++;
            if (rd_res !== 12'h000) begin errors++; $display("FAIL rstmid_slot%0d: got %0h want 0", i, rd_res); end
        end
    endtask

`ifdef A2D_AVG_EN
    task automatic test_avg();
        int n0;
        bit ok;
        pulse_reset();
        rsp_ramp = 1'b1;
        n0 = q_ch.size();
        en = 1'b1;
        wait_starts(n0 + 4, 200, ok);
        en = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (!ok || q_ch.size() != n0 + 4) begin errors++; $display("FAIL avg_starts: got %0d want 4", q_ch.size() - n0); end
        for (int i = 0; i < 4 && ok; i++) begin
            checks++;
            if (q_ch[n0+i] != 0) begin errors++; $display("FAIL avg_seq[%0d]: got ch %0d want 0", i, q_ch[n0+i]); end
        end
        rd_chnnl = 3'd0; #1;
        checks++; if (rd_res !== 12'h002) begin errors++; $display("FAIL avg_slot0: got %0h want 002", rd_res); end
    endtask
`endif

    initial begin : main
        rst_n     = 1'b0;
        en        = 1'b0;
        led_sel   = '0;
        rd_chnnl  = '0;
        rsp_on    = 1'b0;
        rsp_dly   = 5;
        rsp_add   = '0;
        rsp_mute  = '0;
        rsp_ramp  = 1'b0;
        man_cmplt = 1'b0;
        man_res   = '0;
        test_reset();
        test_scan_wrap();
        test_timeout();
        test_cmplt_on_timeout();
        test_stray_and_latency();
        test_en_drop();
        test_reset_mid_wait();
`ifdef A2D_AVG_EN
        test_avg();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
